period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 115 +++++++++++
 tb/tb_period_meter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the sig_in period and high time in fin cycles between synchronized rising
// edges, and flags lock against the expected period DIVN and timeout when edges stop.
module period_meter #(
    parameter logic [31:0] TIMEOUT = 32'd1_000_000,
    parameter int unsigned LOCKN   = 4
) (
    input  logic        fin,
    input  logic        rst,
    input  logic        sig_in,
    input  logic [31:0] DIVN,
    output logic [31:0] period,
    output logic [31:0] high_cnt,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);
    localparam int unsigned MW = (LOCKN < 1) ? 1 : $clog2(LOCKN + 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCKN);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    state_t        state;
    logic          s1;
    logic          s2;
    logic          s3;
    logic [31:0]   cnt;
    logic [31:0]   hcnt;
    logic [31:0]   divn_q;
    logic [MW-1:0] match_cnt;

    logic          rise;
    logic          meas_done;
    logic          tmo_hit;
    logic          divn_chg;
    logic          period_ok;
    logic [MW-1:0] match_nxt;

    // valid is a one-cycle strobe with no back-pressure; period/high_cnt stay
    // stable from that strobe until the next one (or reset).
    always_comb begin
        rise      = s2 & ~s3;
        meas_done = (state == MEAS) && rise;
        tmo_hit   = (state == MEAS) && !rise && (cnt == TIMEOUT);
        divn_chg  = (DIVN != divn_q);
        period_ok = (cnt == divn_q) && (divn_q >= 32'd2);
        match_nxt = match_cnt;
        // A DIVN change outranks any match completing in the same cycle.
        if (divn_chg || tmo_hit) begin
            match_nxt = '0;
        end else if (meas_done) begin
            if (!period_ok) begin
                match_nxt = '0;
            end else if (match_cnt < LOCK_MAX) begin
                match_nxt = match_cnt + MW'(1);
            end
        end
    end

    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt       <= '0;
            hcnt      <= '0;
            divn_q    <= '0;
            match_cnt <= '0;
            period    <= '0;
            high_cnt  <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            s1        <= sig_in;
            s2        <= s1;
            s3        <= s2;
            divn_q    <= DIVN;
            valid     <= 1'b0;
            match_cnt <= match_nxt;
            locked    <= (match_nxt >= LOCK_MAX);
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEAS;
                        cnt   <= 32'd1;
                        hcnt  <= 32'd1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period   <= cnt;
                        high_cnt <= hcnt;
                        valid    <= 1'b1;
                        cnt      <= 32'd1;
                        hcnt     <= 32'd1;
                        timeout  <= 1'b0;
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (s2) begin
                            hcnt <= hcnt + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed scenarios plus random waveforms, checked every
// cycle against a sample-history model of the meter.
module tb_period_meter;
    localparam int TMO   = 100;
    localparam int LOCKN = 4;

    logic        fin = 1'b0;
    logic        rst;
    logic        sig_in;
    logic [31:0] DIVN;
    logic [31:0] period;
    logic [31:0] high_cnt;
    logic        valid;
    logic        locked;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    period_meter #(.TIMEOUT(32'(TMO)), .LOCKN(LOCKN)) dut (
        .fin      (fin),
        .rst      (rst),
        .sig_in   (sig_in),
        .DIVN     (DIVN),
        .period   (period),
        .high_cnt (high_cnt),
        .valid    (valid),
        .locked   (locked),
        .timeout  (timeout)
    );

    // ---------------- clock ----------------
    always #5 fin = ~fin;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] per;
        logic [31:0] hi;
        logic        lk;
        logic        to;
    } vrec_t;
    vrec_t vlog[$];

    task automatic check_rec(input string name, input int idx, input int per, input int hi,
                             input logic lk);
        if (idx >= vlog.size()) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: valid record %0d missing, have %0d", name, idx, vlog.size());
        end else begin
            check({name, "_period"}, vlog[idx].per, 32'(per));
            check({name, "_high"}, vlog[idx].hi, 32'(hi));
            check({name, "_locked"}, {31'd0, vlog[idx].lk}, {31'd0, lk});
        end
    endtask

    // ---------------- reference model ----------------
    // hist holds fin-sampled sig_in values since reset, preceded by zeros for the
    // cleared synchronizer; the output after a fin edge reflects the sample two edges back.
    bit          hist[$];
    bit          armed;
    int          r1;
    int          match;
    logic [31:0] divn_prev;
    logic        m_valid;
    logic        m_locked;
    logic        m_timeout;
    logic [31:0] m_period;
    logic [31:0] m_high;
    logic [63:0] exp_q[$];

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back(1'b0);
        armed     = 1'b0;
        r1        = 0;
        match     = 0;
        divn_prev = '0;
        m_valid   = 1'b0;
        m_locked  = 1'b0;
        m_timeout = 1'b0;
        m_period  = '0;
        m_high    = '0;
        exp_q.delete();
    endtask

    always @(posedge fin or posedge rst) begin : model
        int j;
        int per;
        int hi;
        bit ev_valid;
        bit ev_tmo;
        if (rst) begin
            model_reset();
        end else begin
            hist.push_back(sig_in);
            j        = hist.size() - 3;
            ev_valid = 1'b0;
            ev_tmo   = 1'b0;
            per      = 0;
            m_valid  = 1'b0;
            if (hist[j] && !hist[j-1]) begin
                if (armed) begin
                    per = j - r1;
                    hi  = 0;
                    for (int k = r1; k < j; k++) hi += int'(hist[k]);
                    m_period  = 32'(per);
                    m_high    = 32'(hi);
                    m_valid   = 1'b1;
                    m_timeout = 1'b0;
                    ev_valid  = 1'b1;
                    exp_q.push_back({32'(per), 32'(hi)});
                end
                armed = 1'b1;
                r1    = j;
            end else if (armed && (j - r1 == TMO)) begin
                armed     = 1'b0;
                m_timeout = 1'b1;
                ev_tmo    = 1'b1;
            end
            if (DIVN != divn_prev || ev_tmo) begin
                match = 0;
            end else if (ev_valid) begin
                if (32'(per) == DIVN && DIVN >= 32'd2) match = (match < LOCKN) ? match + 1 : match;
                else match = 0;
            end
            divn_prev = DIVN;
            m_locked  = (match >= LOCKN);
        end
    end

    // ---------------- compare / scoreboard ----------------
    always @(negedge fin) begin : compare
        logic [63:0] e;
        check("valid", {31'd0, valid}, {31'd0, m_valid});
        check("locked", {31'd0, locked}, {31'd0, m_locked});
        check("timeout", {31'd0, timeout}, {31'd0, m_timeout});
        check("period", period, m_period);
        check("high_cnt", high_cnt, m_high);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty: no expected measurement queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_period", period, e[63:32]);
                check("sb_high", high_cnt, e[31:0]);
            end
        end
        if (valid === 1'b1) vlog.push_back('{period, high_cnt, locked, timeout});
    end

    // ---------------- drivers ----------------
    task automatic drive_wave(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < per; c++) begin
                @(negedge fin);
                sig_in = (c < hi);
            end
        end
    endtask

    task automatic hold_low(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge fin);
            sig_in = 1'b0;
        end
    endtask

    task automatic pulse_rst(input int pre, input int cycles, input int post);
        @(negedge fin);
        #(pre);
        rst = 1'b1;
        repeat (cycles) @(negedge fin);
        #(post);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_period"}, period, 32'd0);
        check({name, "_high"}, high_cnt, 32'd0);
        check({name, "_valid"}, {31'd0, valid}, 32'd0);
        check({name, "_locked"}, {31'd0, locked}, 32'd0);
        check({name, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int base;
        int per;
        int hi;
        rst    = 1'b1;
        sig_in = 1'b0;
        DIVN   = 32'd10;
        repeat (3) @(negedge fin);
        check_zero("reset");
        #2 rst = 1'b0;

        // 50% wave of period 10, DIVN 10: first edge arms, lock on 4th valid.
        base = vlog.size();
        drive_wave(10, 5, 6);
        check("p1_count", 32'(vlog.size() - base), 32'd5);
        check_rec("p1_v1", base, 10, 5, 1'b0);
        check_rec("p1_v3", base + 2, 10, 5, 1'b0);
        check_rec("p1_v4", base + 3, 10, 5, 1'b1);
        check("p1_locked", {31'd0, locked}, 32'd1);

        // One period of 12 breaks lock, four periods of 10 restore it.
        base = vlog.size();
        drive_wave(12, 6, 1);
        drive_wave(10, 5, 5);
        check_rec("p2_v12", base + 1, 12, 6, 1'b0);
        check_rec("p2_r3", base + 4, 10, 5, 1'b0);
        check_rec("p2_r4", base + 5, 10, 5, 1'b1);

        // DIVN change drops lock on the next cycle; relock at the new period.
        DIVN = 32'd20;
        @(negedge fin);
        check("p3_unlock", {31'd0, locked}, 32'd0);
        base = vlog.size();
        drive_wave(20, 10, 6);
        check_rec("p3_v11", base, 11, 5, 1'b0);
        check_rec("p3_r3", base + 3, 20, 10, 1'b0);
        check_rec("p3_r4", base + 4, 20, 10, 1'b1);

        // Held low: timeout rises exactly TMO cycles after the last edge is seen.
        hold_low(83);
        check("p4_before_tmo", {31'd0, timeout}, 32'd0);
        @(negedge fin);
        check("p4_tmo", {31'd0, timeout}, 32'd1);
        check("p4_tmo_unlock", {31'd0, locked}, 32'd0);
        base = vlog.size();
        drive_wave(10, 5, 3);
        check("p4_count", 32'(vlog.size() - base), 32'd2);
        check_rec("p4_v1", base, 10, 5, 1'b0);
        if (vlog.size() > base) check("p4_v1_tmo", {31'd0, vlog[base].to}, 32'd0);

        // Period equal to TIMEOUT still measures; one cycle longer times out.
        base = vlog.size();
        drive_wave(TMO, 1, 2);
        drive_wave(TMO + 1, 1, 2);
        check("p5_count", 32'(vlog.size() - base), 32'd3);
        check_rec("p5_v10", base, 10, 5, 1'b0);
        check_rec("p5_v100a", base + 1, TMO, 1, 1'b0);
        check_rec("p5_v100b", base + 2, TMO, 1, 1'b0);
        check("p5_tmo", {31'd0, timeout}, 32'd1);

        // Reset mid-period, off the clock edge: outputs clear at once.
        drive_wave(10, 5, 2);
        @(negedge fin);
        sig_in = 1'b1;
        repeat (2) @(negedge fin);
        #3 rst = 1'b1;
        #1 check_zero("midrst");
        sig_in = 1'b0;
        repeat (3) @(negedge fin);
        #4 rst = 1'b0;
        base = vlog.size();
        drive_wave(10, 5, 3);
        check("p6_count", 32'(vlog.size() - base), 32'd2);
        check_rec("p6_v1", base, 10, 5, 1'b0);

        // Minimum period: sig_in toggles every fin cycle.
        base = vlog.size();
        drive_wave(2, 1, 8);
        hold_low(4);
        #1;
        check("p7_count", 32'(vlog.size() - base), 32'd8);
        check_rec("p7_v10", base, 10, 5, 1'b0);
        for (int k = 1; k < 8; k++) check_rec("p7_min", base + k, 2, 1, 1'b0);

        // Random waveforms, DIVN changes, long gaps and asynchronous resets.
        for (int s = 0; s < 120; s++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                hold_low($urandom_range(TMO - 10, TMO + 30));
            end else if (r < 12) begin
                pulse_rst($urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 4));
            end else if (r < 30) begin
                case ($urandom_range(0, 3))
                    0:       DIVN = 32'($urandom_range(0, 1));
                    1:       DIVN = 32'($urandom_range(2, 40));
                    default: DIVN = 32'($urandom_range(8, 16));
                endcase
            end else begin
                if ($urandom_range(0, 1) == 1 && DIVN >= 32'd2 && DIVN <= 32'd40) per = int'(DIVN);
                else per = $urandom_range(2, 40);
                hi = $urandom_range(1, per - 1);
                drive_wave(per, hi, $urandom_range(1, 8));
            end
        end

        hold_low(5);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
